switch_onehot_decoder: RTL and testbench

//  Parametrised, registered successor to the switch-to-LED decoder.
//  - Synchronises an IN_W-bit switch bus and debounces it as a whole word.
//  - Decodes the debounced code k to one-hot LED bit k-1; code 0 means all LEDs off.
//  - Adds a change strobe, an enable and a lamp-test mode.
//  - Sits between the board switch pins and the LED pins or downstream logic.

---
 rtl/switch_onehot_decoder_pkg.sv | 39 +++
 rtl/switch_onehot_decoder_bus_debounce.sv | 53 +++++
 rtl/switch_onehot_decoder.sv | 70 +++++++
 tb/tb_switch_onehot_decoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/switch_onehot_decoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | switch_onehot_decoder_pkg : shared constants, clog2 and decode fn  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package switch_onehot_decoder_pkg;

  localparam int c_MAX_IN_W  = 6;
  localparam int c_MAX_OUT_W = (1 << c_MAX_IN_W) - 1;

  // Board default: enough hold time to ride out contact bounce at the system clock.
  localparam int c_DEFAULT_DEBOUNCE_CYCLES = 16;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >>> 1;
      end
    end
    return r;
  endfunction

  // Code 0 lights nothing; code k lights bit k-1.
  function automatic logic [c_MAX_OUT_W-1:0] dec(input logic [c_MAX_IN_W-1:0] k);
    logic [c_MAX_OUT_W-1:0] r;
    r = '0;
    if (k != '0) begin
      r = c_MAX_OUT_W'(1) << (k - c_MAX_IN_W'(1));
    end
    return r;
  endfunction

endpackage : switch_onehot_decoder_pkg
`default_nettype wire

// File: rtl/switch_onehot_decoder_bus_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bus_debounce : two-flop synchroniser plus whole-word debouncer     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module bus_debounce
  import switch_onehot_decoder_pkg::*;
#(
  parameter int W               = 2,
  parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] stable
);

  localparam int                 c_CNT_W    = clog2(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]       r_sync1;
  logic [W-1:0]       r_sync2;
  logic [W-1:0]       r_cand;
  logic [W-1:0]       r_stable;
  logic [c_CNT_W-1:0] r_cnt;

  // Any difference against the candidate restarts the hold count, so a glitch
  // landing on the accept edge wins over the old candidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt != c_CNT_LAST) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end else begin
        r_stable <= r_cand;
      end
    end
  end

  assign stable = r_stable;

endmodule : bus_debounce
`default_nettype wire

// File: rtl/switch_onehot_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | switch_onehot_decoder : debounced switch code to one-hot LED drive |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module switch_onehot_decoder
  import switch_onehot_decoder_pkg::*;
#(
  parameter int IN_W            = 2,
  parameter int OUT_W           = (1 << IN_W) - 1,
  parameter int DEBOUNCE_CYCLES = c_DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  switch,
  input  logic             en,
  input  logic             lamp_test,
  output logic [OUT_W-1:0] led,
  output logic [IN_W-1:0]  code,
  output logic             changed
);

  logic [IN_W-1:0]  w_stable;
  logic [OUT_W-1:0] w_dec;
  logic [OUT_W-1:0] w_led_nxt;

  logic [IN_W-1:0]  r_code;
  logic [OUT_W-1:0] r_led;
  logic             r_changed;

  bus_debounce #(
    .W               (IN_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (switch),
    .stable (w_stable)
  );

  assign w_dec = OUT_W'(dec(c_MAX_IN_W'(w_stable)));

  // Lamp test beats enable; neither touches the code path.
  always_comb begin
    w_led_nxt = w_dec;
    if (lamp_test) begin
      w_led_nxt = '1;
    end else if (!en) begin
      w_led_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code    <= '0;
      r_led     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_code    <= w_stable;
      r_changed <= (w_stable != r_code);
      r_led     <= w_led_nxt;
    end
  end

  assign led     = r_led;
  assign code    = r_code;
  assign changed = r_changed;

endmodule : switch_onehot_decoder
`default_nettype wire

// File: tb/tb_switch_onehot_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_switch_onehot_decoder : directed self-checking bench            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_switch_onehot_decoder;

  logic       clk;
  logic       rst_n;
  logic [1:0] switch;
  logic       en;
  logic       lamp_test;
  logic [2:0] led;
  logic [1:0] code;
  logic       changed;

  int n_checks = 0;
  int n_errors = 0;

  switch_onehot_decoder #(
    .IN_W            (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .switch    (switch),
    .en        (en),
    .lamp_test (lamp_test),
    .led       (led),
    .code      (code),
    .changed   (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Edge e is the e-th rising edge after the caller's stimulus; the new value
  // must appear exactly at edge 8 with a single changed pulse.
  task automatic track(input string tag, input logic [2:0] old_led, input logic [1:0] old_code,
                       input logic [2:0] new_led, input logic [1:0] new_code, input int n);
    int pulses;
    pulses = 0;
    for (int e = 1; e <= n; e++) begin
      @(negedge clk);
      if (changed) pulses++;
      if (e < 8) begin
        check({tag, "_led_old"}, led, old_led);
        check({tag, "_code_old"}, code, old_code);
      end else begin
        check({tag, "_led_new"}, led, new_led);
        check({tag, "_code_new"}, code, new_code);
      end
      if (e == 8) check({tag, "_chg_e8"}, changed, 1);
    end
    check({tag, "_pulses"}, pulses, 1);
  endtask

  task automatic change_code(input string tag, input logic [1:0] sw, input logic [2:0] old_led,
                             input logic [1:0] old_code, input logic [2:0] new_led,
                             input logic [1:0] new_code, input int n);
    @(negedge clk);
    switch = sw;
    track(tag, old_led, old_code, new_led, new_code, n);
  endtask

  initial begin
    rst_n     = 1'b0;
    switch    = 2'b00;
    en        = 1'b1;
    lamp_test = 1'b0;

    // Reset state, then held quiet for 20 cycles after release
    repeat (3) @(negedge clk);
    check("rst_led", led, 3'b000);
    check("rst_code", code, 2'b00);
    check("rst_chg", changed, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_led", led, 3'b000);
      check("idle_code", code, 2'b00);
      check("idle_chg", changed, 0);
    end

    // 00 -> 11: max code lights only the top LED
    change_code("to11", 2'b11, 3'b000, 2'b00, 3'b100, 2'b11, 20);

    // Walk
    change_code("w01", 2'b01, 3'b100, 2'b11, 3'b001, 2'b01, 20);
    change_code("w10", 2'b10, 3'b001, 2'b01, 3'b010, 2'b10, 20);
    change_code("w11", 2'b11, 3'b010, 2'b10, 3'b100, 2'b11, 20);
    change_code("w00", 2'b00, 3'b100, 2'b11, 3'b000, 2'b00, 20);

    // Short glitch is never accepted
    @(negedge clk);
    switch = 2'b01;
    repeat (3) @(negedge clk);
    switch = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("glitch_led", led, 3'b000);
      check("glitch_code", code, 2'b00);
      check("glitch_chg", changed, 0);
    end

    // Lamp test and enable
    change_code("to10", 2'b10, 3'b000, 2'b00, 3'b010, 2'b10, 20);
    lamp_test = 1'b1;
    @(negedge clk);
    check("lamp_led", led, 3'b111);
    check("lamp_code", code, 2'b10);
    check("lamp_chg", changed, 0);
    lamp_test = 1'b0;
    en        = 1'b0;
    @(negedge clk);
    check("dis_led", led, 3'b000);
    check("dis_code", code, 2'b10);
    check("dis_chg", changed, 0);
    en = 1'b1;
    @(negedge clk);
    check("en_led", led, 3'b010);
    check("en_code", code, 2'b10);

    // Back to 00, then reset in the middle of a 00 -> 10 debounce
    change_code("back00", 2'b00, 3'b010, 2'b10, 3'b000, 2'b00, 20);
    @(negedge clk);
    switch = 2'b10;
    repeat (4) @(negedge clk);
    lamp_test = 1'b1;
    @(negedge clk);
    check("pre_rst_led", led, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_led", led, 3'b000);
    check("async_code", code, 2'b00);
    check("async_chg", changed, 0);
    lamp_test = 1'b0;
    repeat (3) @(negedge clk);
    check("inrst_led", led, 3'b000);
    check("inrst_code", code, 2'b00);
    rst_n = 1'b1;
    track("post_rst", 3'b000, 2'b00, 3'b010, 2'b10, 12);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_switch_onehot_decoder
`default_nettype wire
